// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target with oversampled SCL/SDA, write/read byte interfaces; optional GENERAL_CALL_EN
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       rw,
    output logic       busy,
    output logic       nack_err
`ifdef GENERAL_CALL_EN
    ,
    output logic       gc_hit
`endif
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] WR_DATA   = 3'd3;
    localparam logic [2:0] WR_ACK    = 3'd4;
    localparam logic [2:0] RD_DATA   = 3'd5;
    localparam logic [2:0] RD_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       sda_oe;
    logic       ack_phase;
    logic       wr_done;
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_hist;
    logic       sda_hist;

    logic scl_rise, scl_fall, start_det, stop_det, gc_match, addr_hit;

    // Open-drain: only ever pull low or release.
    assign SDA = sda_oe ? 1'b0 : 1'bz;

    assign scl_rise  = scl_sync[1] & ~scl_hist;
    assign scl_fall  = ~scl_sync[1] & scl_hist;
    // Our own SDA drive must never look like a bus condition.
    assign start_det = ~sda_oe & scl_sync[1] & scl_hist & sda_hist & ~sda_sync[1];
    assign stop_det  = ~sda_oe & scl_sync[1] & scl_hist & ~sda_hist & sda_sync[1];

`ifdef GENERAL_CALL_EN
    logic gc_flag;
    assign gc_match = (shreg[6:0] == 7'd0) & ~sda_sync[1];
    assign gc_hit   = gc_flag & busy;
`else
    assign gc_match = 1'b0;
`endif

    assign addr_hit = (shreg[6:0] == SLAVE_ADDR) | gc_match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            sda_oe    <= 1'b0;
            ack_phase <= 1'b0;
            wr_done   <= 1'b0;
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_hist  <= 1'b1;
            sda_hist  <= 1'b1;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
            nack_err  <= 1'b0;
`ifdef GENERAL_CALL_EN
            gc_flag   <= 1'b0;
`endif
        end else begin
            scl_sync <= {scl_sync[0], SCL};
            sda_sync <= {sda_sync[0], SDA};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            nack_err <= 1'b0;
            wr_done  <= 1'b0;

            // A completed byte is published one clk after its last bit.
            if (wr_done) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end

            if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= 3'd0;
                shreg     <= 8'd0;
                busy      <= 1'b0;
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
`ifdef GENERAL_CALL_EN
                gc_flag   <= 1'b0;
`endif
            end else if (stop_det) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                ack_phase <= 1'b0;
`ifdef GENERAL_CALL_EN
                gc_flag   <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_sync[1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (addr_hit) begin
                                    rw        <= sda_sync[1];
                                    ack_phase <= 1'b0;
                                    state     <= ADDR_ACK;
`ifdef GENERAL_CALL_EN
                                    gc_flag   <= gc_match;
`endif
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                busy      <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= 3'd0;
                                if (rw) begin
                                    tx_load <= 1'b1;
                                    shreg   <= tx_data;
                                    sda_oe  <= ~tx_data[7];
                                    state   <= RD_DATA;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= WR_DATA;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_sync[1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                wr_done   <= 1'b1;
                                ack_phase <= 1'b0;
                                state     <= WR_ACK;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                ack_phase <= 1'b0;
                                state     <= WR_DATA;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe    <= 1'b0;
                                bit_cnt   <= 3'd0;
                                ack_phase <= 1'b0;
                                state     <= RD_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_oe  <= ~shreg[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        // ack_phase here marks "master ACK seen, reload on next fall".
                        if (scl_rise && !ack_phase) begin
                            if (sda_sync[1]) begin
                                nack_err <= 1'b1;
                                state    <= WAIT_STOP;
                            end else begin
                                ack_phase <= 1'b1;
                            end
                        end else if (scl_fall && ack_phase) begin
                            tx_load   <= 1'b1;
                            shreg     <= tx_data;
                            sda_oe    <= ~tx_data[7];
                            ack_phase <= 1'b0;
                            state     <= RD_DATA;
                        end
                    end
                    WAIT_STOP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - randomized scoreboard bench for i2c_slave with bit-banged master
module tb_i2c_slave;

    localparam int QC = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_sda;
    wire        sda_bus;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid, tx_load, rw, busy, nack_err;
`ifdef GENERAL_CALL_EN
    logic       gc_hit;
`endif

    always #5 clk = ~clk;

    assign sda_bus = m_sda ? 1'bz : 1'b0;
    pullup (sda_bus);

    i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
        .clk      (clk),
        .reset    (reset),
        .SCL      (scl),
        .SDA      (sda_bus),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_load  (tx_load),
        .rw       (rw),
        .busy     (busy),
        .nack_err (nack_err)
`ifdef GENERAL_CALL_EN
        ,
        .gc_hit   (gc_hit)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];
    int  tx_load_cnt = 0;
    int  nack_cnt = 0;
    bit  slave_drove = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected bytes when the DUT presents them.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (m_sda && sda_bus === 1'b0) slave_drove = 1'b1;
                if (rx_valid) begin
                    if (exp_rx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected actual=%0h expected=none", rx_data);
                    end else begin
                        check("rx_data", rx_data, exp_rx.pop_front());
                    end
                end
                if (rx_valid || tx_load) check("rx_tx_exclusive", rx_valid & tx_load, 0);
                if (tx_load) begin
                    tx_load_cnt++;
                    if (tx_q.size() != 0) tx_q.delete(0);
                    tx_data = (tx_q.size() != 0) ? tx_q[0] : 8'hFF;
                end
                if (nack_err) nack_cnt++;
            end
        end
    end

    task automatic q();
        repeat (QC) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; q(); scl = 1'b1; q(); m_sda = 1'b0; q(); scl = 1'b0; q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; q(); scl = 1'b1; q(); m_sda = 1'b1; q(); q();
    endtask

    task automatic write_bit(input bit b);
        m_sda = b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
    endtask

    task automatic read_bit(output bit b);
        m_sda = 1'b1; q(); scl = 1'b1; q(); b = sda_bus; q(); scl = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        bit x;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(x);
        ack = ~x;
    endtask

    task automatic read_byte(output logic [7:0] d, input bit nack);
        bit x;
        for (int i = 7; i >= 0; i--) begin
            read_bit(x);
            d[i] = x;
        end
        write_bit(nack);
    endtask

    // Reference: which address bytes the target answers.
    function automatic bit addr_acked(input logic [7:0] a);
`ifdef GENERAL_CALL_EN
        return (a[7:1] == 7'h42) || (a == 8'h00);
`else
        return a[7:1] == 7'h42;
`endif
    endfunction

    task automatic do_write(input logic [7:0] a, input int n, input string tag);
        bit ack;
        bit hit;
        logic [7:0] d;
        hit = addr_acked(a);
        i2c_start();
        write_byte(a, ack);
        check({tag, "_addr_ack"}, ack, hit);
        if (hit) check({tag, "_busy"}, busy, 1);
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            if (hit) exp_rx.push_back(d);
            write_byte(d, ack);
            check({tag, "_data_ack"}, ack, hit);
        end
        i2c_stop();
        check({tag, "_busy_after_stop"}, busy, 0);
        check({tag, "_rx_drained"}, exp_rx.size(), 0);
    endtask

    task automatic do_read(input logic [7:0] a, input int n, input string tag);
        bit ack;
        bit hit;
        logic [7:0] exp_bytes[$];
        logic [7:0] got;
        hit = addr_acked(a);
        tx_q.delete();
        for (int i = 0; i < n; i++) begin
            tx_q.push_back(8'($urandom));
            exp_bytes.push_back(hit ? tx_q[i] : 8'hFF);
        end
        tx_data = tx_q[0];
        tx_load_cnt = 0;
        nack_cnt = 0;
        i2c_start();
        write_byte(a, ack);
        check({tag, "_addr_ack"}, ack, hit);
        if (hit) check({tag, "_rw"}, rw, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(got, i == n - 1);
            check({tag, "_rd_byte"}, got, exp_bytes[i]);
        end
        i2c_stop();
        check({tag, "_tx_load_cnt"}, tx_load_cnt, hit ? n : 0);
        check({tag, "_nack_cnt"}, nack_cnt, hit ? 1 : 0);
        check({tag, "_busy_after_stop"}, busy, 0);
    endtask

    initial begin
        bit ack;
        logic [7:0] got;
        logic [7:0] a;

        reset = 1'b0; scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_data", rx_data, 0);
        check("reset_outputs", {rx_valid, tx_load, rw, busy, nack_err}, 0);
        check("reset_sda", sda_bus, 1);
        reset = 1'b1;
        q();

        // Directed write: 0xA5, 0x3C
        i2c_start();
        write_byte(8'h84, ack);
        check("wr_addr_ack", ack, 1);
        check("wr_busy", busy, 1);
        check("wr_rw", rw, 0);
        exp_rx.push_back(8'hA5);
        write_byte(8'hA5, ack);
        check("wr_ack1", ack, 1);
        exp_rx.push_back(8'h3C);
        write_byte(8'h3C, ack);
        check("wr_ack2", ack, 1);
        check("wr_rx_last", rx_data, 8'h3C);
        i2c_stop();
        check("wr_busy_stop", busy, 0);
        check("wr_rx_drained", exp_rx.size(), 0);

        // Directed read: 0x5A then 0xC3
        tx_q.delete();
        tx_q.push_back(8'h5A);
        tx_q.push_back(8'hC3);
        tx_data = 8'h5A;
        tx_load_cnt = 0;
        nack_cnt = 0;
        i2c_start();
        write_byte(8'h85, ack);
        check("rd_addr_ack", ack, 1);
        check("rd_rw", rw, 1);
        read_byte(got, 1'b0);
        check("rd_byte1", got, 8'h5A);
        read_byte(got, 1'b1);
        check("rd_byte2", got, 8'hC3);
        i2c_stop();
        check("rd_tx_load_cnt", tx_load_cnt, 2);
        check("rd_nack_cnt", nack_cnt, 1);

        // Address mismatch, then a normal write
        slave_drove = 1'b0;
        do_write(8'h90, 1, "mismatch");
        check("mismatch_sda_never_low", slave_drove, 0);
        do_write(8'h84, 1, "after_mismatch");

        // Repeated START
        i2c_start();
        write_byte(8'h84, ack);
        exp_rx.push_back(8'h01);
        write_byte(8'h01, ack);
        check("rs_ack", ack, 1);
        tx_q.delete();
        tx_q.push_back(8'h96);
        tx_data = 8'h96;
        i2c_start();
        write_byte(8'h85, ack);
        check("rs_addr2_ack", ack, 1);
        check("rs_rw", rw, 1);
        check("rs_rx_data", rx_data, 8'h01);
        read_byte(got, 1'b1);
        check("rs_rd_byte", got, 8'h96);
        i2c_stop();

        // Abort after 4 data bits: no rx_valid may appear
        i2c_start();
        write_byte(8'h84, ack);
        for (int i = 0; i < 4; i++) write_bit(1'($urandom));
        i2c_stop();
        check("abort_busy", busy, 0);
        do_write(8'h84, 1, "after_abort");

        // Reset while the target holds SDA low in the ACK slot
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 2 || i == 7);
        m_sda = 1'b1; q(); scl = 1'b1; q();
        check("rst_pre_ack_low", sda_bus, 0);
        reset = 1'b0;
        #1;
        check("rst_sda_released", sda_bus, 1);
        check("rst_outputs", {rx_data, rx_valid, tx_load, rw, busy, nack_err}, 0);
        scl = 1'b0; q();
        reset = 1'b1;
        i2c_stop();
        do_write(8'h84, 2, "after_reset");

`ifdef GENERAL_CALL_EN
        i2c_start();
        write_byte(8'h00, ack);
        check("gc_ack", ack, 1);
        check("gc_hit", gc_hit, 1);
        i2c_stop();
        check("gc_hit_clear", gc_hit, 0);
`endif

        // Randomized transfers checked against the address/data model
        for (int it = 0; it < 10; it++) begin
            a = ($urandom_range(0, 1) == 1) ? 8'h84 : 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                a[0] = 1'b0;
                do_write(a, $urandom_range(1, 3), "rand_wr");
            end else begin
                a[0] = 1'b1;
                do_read(a, $urandom_range(1, 3), "rand_rd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target that sits directly downstream of i2c_master on the shared SDA/SCL bus.
- Oversamples SCL/SDA on its own clock and decodes START, STOP and address.
- Write transfers: received bytes are presented on a byte-wide valid interface.
- Read transfers: bytes are fetched from a load interface and shifted out on SDA.
- Acts as the bench partner and the on-chip peripheral endpoint for the master.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this target answers to.

Ports:
- clk  input  1  System clock. Must be at least 8x the master's state-machine clock.
- reset  input  1  Asynchronous reset, active-low.
- SCL  input  1  I2C clock (open-drain bus, read only; no clock stretching).
- SDA  inout  1  I2C data. Driven to 0 or released (z), never driven to 1.
- tx_data  input  8  Byte to return on read; sampled when tx_load pulses.
- rx_data  output  8  Last byte written by the master.
- rx_valid  output  1  One-clk pulse when rx_data is updated.
- tx_load  output  1  One-clk pulse when tx_data is captured into the shift register.
- rw  output  1  R/W bit of the last matched address byte (1 = read).
- busy  output  1  High while addressed, from address ACK until STOP or a repeated START.
- nack_err  output  1  One-clk pulse when the master NACKs a read byte.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, SDA released, bit counter 0.
  - rx_data=0, rx_valid=0, tx_load=0, rw=0, busy=0, nack_err=0.
  - Reset asserted mid-transfer releases SDA immediately, regardless of SCL.
- Input sampling: SCL and SDA each pass through a 2-FF synchronizer plus one history stage. Edges are seen 3 clk after the bus change.
- START: synced SDA 1->0 while synced SCL=1. STOP: synced SDA 1->0... rather 0->1 while SCL=1.
- START/STOP detection is disabled while this block drives SDA low.
- START in any state: go to ADDR, clear counter and shift register, busy=0. Repeated START is supported.
- STOP in any state: go to IDLE, release SDA, busy=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift SDA MSB-first on each SCL rising edge, 8 bits. After the 8th bit, compare bits [7:1] with SLAVE_ADDR.
    - Match: latch rw, go to ADDR_ACK.
    - No match: go to WAIT_STOP, SDA never driven.
  - ADDR_ACK: drive SDA=0 from the next SCL falling edge to the following SCL falling edge. busy=1 from the first of those falling edges.
    - rw=0: at the release edge go to WR_DATA.
    - rw=1: at the release edge pulse tx_load, load tx_data, drive its MSB (0 -> drive low, 1 -> release), go to RD_DATA.
  - WR_DATA: sample 8 bits on SCL rising edges.
    - On the 8th rising edge + 1 clk: rx_data updated and rx_valid pulses.
    - Then go to WR_ACK.
  - WR_ACK: unconditional ACK (SDA=0 from next SCL fall to the following fall), then return to WR_DATA.
  - RD_DATA: present the next bit on each SCL falling edge. After the 8th bit's falling edge, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on SCL rising edge.
    - 0 (ACK): on the next falling edge pulse tx_load, load the next byte, go to RD_DATA.
    - 1 (NACK): pulse nack_err, go to WAIT_STOP.
  - WAIT_STOP: ignore the bus until START or STOP.
- Bit counter: 3 bits, wraps 7->0 at a byte boundary.
- rx_valid and tx_load never assert in the same clk.
- A START or STOP arriving mid-byte aborts the byte. No rx_valid is issued for a partial byte.

Optional Feature:
- GENERAL_CALL_EN defined:
  - Address byte 8'h00 (address 0, write) is also ACKed and handled as a write.
  - rw=0; an additional output gc_hit (1 bit) is high while busy in a general call.
  - Address 0 with read bit set is not ACKed.
- Not defined: address 0 is treated like any other non-matching address. The gc_hit port does not exist.

Test Plan:
- Reset: hold reset=0 mid-byte with SDA driven low -> SDA released within the same clk; all outputs 0; state IDLE after release.
- Write: START, 0x84 (0x42+W), 0xA5, 0x3C, STOP.
  - ACK low during each of 3 ACK slots.
  - rx_valid pulses twice, rx_data=0xA5 then 0x3C.
  - busy falls at STOP.
- Read: START, 0x85, master ACKs byte 1 and NACKs byte 2, STOP; tx_data=0x5A then 0xC3.
  - Bus shows 0x5A then 0xC3.
  - tx_load pulses twice, nack_err pulses once.
- Address mismatch: START, 0x90 -> SDA never driven low, busy stays 0, no rx_valid; next START, 0x84 is ACKed normally.
- Repeated START: START, 0x84, 0x01, repeated START, 0x85 -> rx_data=0x01 and rw=1 after the second address; the read byte is shifted out.
- Abort and general call:
  - STOP after 4 data bits -> no rx_valid, state IDLE.
  - With GENERAL_CALL_EN, address 0x00 is ACKed and gc_hit=1.
